// File: rtl/eth_axis_pkg.sv
// Shared types and helpers for the tx-side AXI-stream arbiter and the
// matching rx-side demux.
package eth_axis_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN
  } arb_state_e;

  // Round-robin pointer advance with wrap at s_count.
  function automatic int rr_next(input int ptr, input int s_count);
    return (ptr + 1 >= s_count) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around; ptr itself has the highest priority.
module arb_rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant_idx = IDX_W'((int'(ptr) + k) % N);
        any       = 1'b1;
      end
    end
    if (any) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter feeding the MAC tx AXI-stream port;
// oversize frames are cut, flagged bad and the remainder discarded.
module eth_tx_frame_arb
  import eth_axis_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_COUNT*8-1:0]       s_axis_tdata,
  input  logic [S_COUNT-1:0]         s_axis_tvalid,
  output logic [S_COUNT-1:0]         s_axis_tready,
  input  logic [S_COUNT-1:0]         s_axis_tlast,
  input  logic [S_COUNT-1:0]         s_axis_tuser,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  input  logic                       enable,
  output logic                       grant_valid,
  output logic [$clog2(S_COUNT)-1:0] grant_idx,
  output logic                       trunc_pulse
);

  localparam int IDX_W = $clog2(S_COUNT);
  localparam bit TRUNC_EN = (MAX_FRAME_LEN > 0);
  localparam logic [LEN_W-1:0] TRUNC_AT = TRUNC_EN ? LEN_W'(MAX_FRAME_LEN - 1) : '0;

  logic [BYTE_W-1:0] lane_data [S_COUNT];

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_lane
    assign lane_data[gi] = s_axis_tdata[gi*BYTE_W +: BYTE_W];
  end

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [S_COUNT-1:0] grant_oh_reg, grant_oh_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [LEN_W-1:0]   len_cnt_reg, len_cnt_next;
  logic               trunc_pulse_reg, trunc_pulse_next;

  logic [S_COUNT-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  arb_rr_select #(
    .N(S_COUNT)
  ) u_sel (
    .req         (s_axis_tvalid),
    .ptr         (ptr_reg),
    .grant_onehot(sel_onehot),
    .grant_idx   (sel_idx),
    .any         (sel_any)
  );

  logic [BYTE_W-1:0] src_data;
  logic              src_valid;
  logic              src_last;
  logic              src_user;
  logic              trunc_hit;

  assign src_data  = lane_data[grant_idx_reg];
  assign src_valid = s_axis_tvalid[grant_idx_reg];
  assign src_last  = s_axis_tlast[grant_idx_reg];
  assign src_user  = s_axis_tuser[grant_idx_reg];
  // A source tlast landing on the final allowed beat is a legal frame, not a cut.
  assign trunc_hit = TRUNC_EN && (len_cnt_reg == TRUNC_AT) && !src_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_idx_reg   <= '0;
      grant_oh_reg    <= '0;
      ptr_reg         <= '0;
      len_cnt_reg     <= '0;
      trunc_pulse_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_idx_reg   <= grant_idx_next;
      grant_oh_reg    <= grant_oh_next;
      ptr_reg         <= ptr_next;
      len_cnt_reg     <= len_cnt_next;
      trunc_pulse_reg <= trunc_pulse_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_idx_next   = grant_idx_reg;
    grant_oh_next    = grant_oh_reg;
    ptr_next         = ptr_reg;
    len_cnt_next     = len_cnt_reg;
    trunc_pulse_next = 1'b0;
    m_axis_tdata     = '0;
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    m_axis_tuser     = 1'b0;
    s_axis_tready    = '0;

    case (state_reg)
      IDLE: begin
        if (enable && sel_any) begin
          grant_idx_next = sel_idx;
          grant_oh_next  = sel_onehot;
          ptr_next       = IDX_W'(rr_next(int'(sel_idx), S_COUNT));
          len_cnt_next   = '0;
          state_next     = PASS;
        end
      end

      PASS: begin
        m_axis_tdata  = src_data;
        m_axis_tvalid = src_valid;
        m_axis_tlast  = src_last || trunc_hit;
        m_axis_tuser  = src_user || trunc_hit;
        s_axis_tready = grant_oh_reg & {S_COUNT{m_axis_tready}};
        if (src_valid && m_axis_tready) begin
          if (len_cnt_reg != '1) begin
            len_cnt_next = len_cnt_reg + 1'b1;
          end
          if (src_last) begin
            state_next = IDLE;
          end else if (trunc_hit) begin
            state_next       = DRAIN;
            trunc_pulse_next = 1'b1;
          end
        end
      end

      DRAIN: begin
        s_axis_tready = grant_oh_reg;
        if (src_valid && src_last) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign grant_valid = (state_reg != IDLE);
  assign grant_idx   = grant_idx_reg;
  assign trunc_pulse = trunc_pulse_reg;

endmodule
